shift_out_stage: RTL

- Registered output stage directly downstream of the 8-bit logical left shifter in the COA-lab ALU datapath.
- Captures the shifter result together with its operands and derives status flags (zero, carry-out, over-range).
- Presents results to the consumer through a valid/ready handshake, backed by a 2-entry skid buffer for full throughput under backpressure.
- Keeps a count of delivered results.

---
 rtl/shift_out_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shift_out_stage.sv
// -----------------------------------------------------------------------------
// shift_out_stage
//
// Registered output stage that sits directly after the logical left shifter
// in the ALU datapath. It captures the shifter result together with status
// flags derived from the shifter operands. Results go to the consumer through
// a valid/ready handshake. A 2-entry skid buffer (main + skid register) keeps
// one beat per cycle flowing under backpressure. The stage also counts the
// results it delivers.
//
// Optional feature (build macro SHIFT_CHECK_EN):
//   When defined, every accepted beat is re-shifted locally and compared with
//   in_res. A disagreement sets the sticky chk_err flag, which clears only on
//   reset. When undefined, no checker logic is built and chk_err is tied to 0.
//
// Parameters:
//   WIDTH  data width of operand a and of the shifter result
//   SHW    width of the shift-amount operand b
//   CNTW   width of the delivered-result counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (registered, equals !skid_full)
//   in_a       operand a fed to the shifter
//   in_b       shift amount fed to the shifter
//   in_res     shifter output for (in_a, in_b)
//   out_valid  output beat valid
//   out_ready  downstream accepts beat
//   out_res    registered result
//   out_zero   out_res == 0
//   out_carry  last bit shifted out of a
//   out_big    shift amount >= WIDTH (result forced to zero)
//   out_count  number of delivered beats (wraps)
//   chk_err    sticky checker error (0 unless SHIFT_CHECK_EN)
// -----------------------------------------------------------------------------
module shift_out_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_b,
  input  logic [WIDTH-1:0] in_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_big,
  output logic [CNTW-1:0]  out_count,
  output logic             chk_err
);

  // A beat is stored as {result, zero, carry, big}.
  localparam int BW = WIDTH + 3;

  // WIDTH expressed in the (zero-extended) shift-amount width.
  localparam logic [SHW:0] WIDTH_X = (SHW + 1)'(WIDTH);

  // Shift amounts of WIDTH or more push every bit of a out of the word.
  function automatic logic big_of(input logic [SHW-1:0] b);
    return ({1'b0, b} >= WIDTH_X);
  endfunction

  // The last bit shifted out is a[WIDTH-b] for 1 <= b <= WIDTH. For b == 0
  // nothing leaves the word, and for b > WIDTH the last bit shifted out is one
  // of the zeros filled in from the right, so both give 0. The loop keeps the
  // bit select constant for every branch.
  function automatic logic carry_of(input logic [WIDTH-1:0] a,
                                    input logic [SHW-1:0]   b);
    logic c;
    c = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      if ({1'b0, b} == (SHW + 1)'(i)) begin
        c = a[WIDTH-i];
      end
    end
    return c;
  endfunction

  function automatic logic zero_of(input logic [WIDTH-1:0] r);
    return (r == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: handshake decode and flag derivation from the live inputs
  // ---------------------------------------------------------------------------
  logic          in_xfer;
  logic          out_xfer;
  logic [BW-1:0] beat_p0;

  logic [BW-1:0]   main_p1;
  logic [BW-1:0]   skid_p1;
  logic            vld_p1;
  logic            skid_vld_p1;
  logic [CNTW-1:0] cnt_p1;

  // skid_vld_p1 is a flop, so in_ready has no combinational path from out_ready.
  assign in_ready = !skid_vld_p1;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p1 && out_ready;

  assign beat_p0 = {in_res, zero_of(in_res), carry_of(in_a, in_b), big_of(in_b)};

  // ---------------------------------------------------------------------------
  // Stage p1: main register (presented beat) and skid register (overflow beat)
  // ---------------------------------------------------------------------------
  // Invariant: the skid entry is only ever occupied while main is occupied, so
  // the presented beat is always the oldest one held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1     <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      if (!vld_p1) begin
        if (in_xfer) begin
          main_p1 <= beat_p0;
          vld_p1  <= 1'b1;
        end
      end else if (out_xfer) begin
        if (skid_vld_p1) begin
          // Oldest pending beat moves up; any new beat takes its place.
          main_p1 <= skid_p1;
          if (in_xfer) begin
            skid_p1 <= beat_p0;
          end else begin
            skid_vld_p1 <= 1'b0;
          end
        end else if (in_xfer) begin
          main_p1 <= beat_p0;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (in_xfer) begin
        // Consumer stalled: park the new beat; in_ready drops next cycle.
        skid_p1     <= beat_p0;
        skid_vld_p1 <= 1'b1;
      end

      if (out_xfer) begin
        cnt_p1 <= cnt_p1 + CNTW'(1);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_res   = main_p1[BW-1:3];
  assign out_zero  = main_p1[2];
  assign out_carry = main_p1[1];
  assign out_big   = main_p1[0];
  assign out_count = cnt_p1;

`ifdef SHIFT_CHECK_EN
  // Independent re-shift of the operands; the truncating cast drops the bits
  // pushed out of the word.
  function automatic logic [WIDTH-1:0] ref_of(input logic [WIDTH-1:0] a,
                                              input logic [SHW-1:0]   b);
    logic [WIDTH-1:0] r;
    if (big_of(b)) begin
      r = '0;
    end else begin
      r = WIDTH'(a << b);
    end
    return r;
  endfunction

  logic chk_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_p1 <= 1'b0;
    end else if (in_xfer && (in_res != ref_of(in_a, in_b))) begin
      chk_p1 <= 1'b1;
    end
  end

  assign chk_err = chk_p1;
`else
  assign chk_err = 1'b0;
`endif

endmodule
